// File: rtl/pezaris_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : pezaris_seq_mult
// Brief    : Sequential two's-complement multiplier, one partial-product row
//            per clock; the top multiplier row has negative weight (Pezaris).
//            Optional macro PEZARIS_UNSIGNED_MODE_EN adds a tc_mode input
//            selecting signed (1) or unsigned (0) operands.
// Revision : 1.0 - initial release
// ============================================================================
module pezaris_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef PEZARIS_UNSIGNED_MODE_EN
    input  logic                 tc_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_row = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_p;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_signed;
    logic                 w_last_row;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_row;
    logic [2*WIDTH-1:0]   w_acc_nxt;

`ifdef PEZARIS_UNSIGNED_MODE_EN
    logic                 r_tc;
    assign w_signed = r_tc;
`else
    assign w_signed = 1'b1;
`endif

    // Row datapath: the last row is subtracted only for signed operands
    assign w_last_row = (r_cnt == c_last_row);
    assign w_a_ext    = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
    assign w_row      = w_a_ext << r_cnt;
    assign w_acc_nxt  = !r_b[r_cnt]               ? r_acc :
                        (w_signed && w_last_row)  ? r_acc - w_row :
                                                    r_acc + w_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs depend on registered state only
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                if (w_last_row) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_p   <= '0;
            r_cnt <= '0;
`ifdef PEZARIS_UNSIGNED_MODE_EN
            r_tc  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef PEZARIS_UNSIGNED_MODE_EN
                        r_tc  <= tc_mode;
`endif
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_row) r_p <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire

// File: doc/pezaris_seq_mult.md
Name: pezaris_seq_mult

Overview:
- Parametrised, multi-cycle two's-complement multiplier for the Pezaris multiplier family.
- Reduces one partial-product row per clock into a 2*WIDTH accumulator. The most-significant multiplier row carries negative weight and is subtracted, which is the Pezaris sign treatment.
- Valid/ready on both sides, so it can sit behind operand FIFOs or in front of the accumulate stage.
- Trades the full array's area for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 4..32.
- CNT_W, $clog2(WIDTH), row-counter width. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand, two's complement
- b  in  WIDTH  multiplier, two's complement
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- p  out  2*WIDTH  product a*b, two's complement, exact (no overflow possible)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (asynchronous on rst_n low):
  - state = IDLE, in_ready = 1, out_valid = 0, p = 0.
  - Internal operand registers, accumulator and row counter all cleared.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: capture a and b, clear the accumulator, set row counter = 0, go to ACCUM.
- ACCUM:
  - in_ready = 0, out_valid = 0.
  - Each edge processes row i = counter.
  - For i < WIDTH-1: acc += sign_extend(a) << i when b[i] = 1.
  - For i = WIDTH-1: acc -= sign_extend(a) << (WIDTH-1) when b[WIDTH-1] = 1 (negative sign weight).
  - All arithmetic is modulo 2^(2*WIDTH).
  - Counter increments each edge. After processing row WIDTH-1: go to DONE, load p from the final accumulator value, assert out_valid.
- DONE:
  - out_valid = 1, in_ready = 0.
  - p is held stable until out_valid && out_ready; on that edge go to IDLE (out_valid = 0, in_ready = 1).
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Minimum accept-to-accept interval is WIDTH+2 edges with out_ready held high: no overlap, and no accept on the same edge as the product handshake.
- Handshake rules:
  - Operands not accepted (in_ready = 0) are ignored.
  - Inputs a and b may change freely after the accepting edge.
  - out_ready is don't-care outside DONE.
  - p keeps its last value in IDLE and ACCUM; it is only meaningful while out_valid = 1.
- Boundary cases:
  - a = -2^(WIDTH-1), b = -2^(WIDTH-1) gives +2^(2*WIDTH-2). The result must be exact; the accumulator width guarantees this.
  - b = 0 or a = 0 gives p = 0, still after the full WIDTH-cycle latency. There is no early termination.
  - rst_n asserted mid-ACCUM or in DONE aborts immediately, returns to reset values and discards the product.
- Outputs in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.

Optional Feature:
- Macro: PEZARIS_UNSIGNED_MODE_EN.
- When defined:
  - Extra input port tc_mode (1 bit), sampled together with a and b on the accepting edge.
  - tc_mode = 1: signed behaviour as above.
  - tc_mode = 0: operands are treated as unsigned. a is zero-extended, and row WIDTH-1 is added (positive weight) rather than subtracted. p is the unsigned 2*WIDTH product.
- When not defined: no tc_mode port; the block is always signed.
- Latency and handshake are identical in both builds.

Test Plan (WIDTH = 8):
- Reset, then a = 0x80 (-128), b = 0x80 (-128), out_ready = 1 -> out_valid exactly 8 edges after accept, p = 0x4000 (16384); one edge later in_ready = 1.
- a = 0xFF (-1), b = 0x01 -> p = 0xFFFF. a = 0x7F (127), b = 0x80 (-128) -> p = 0xC080 (-16256).
- Backpressure: a = 0x05, b = 0xFD (-3), out_ready held 0 for 5 cycles after out_valid -> p = 0xFFF1 held stable, in_ready = 0 throughout, and a new in_valid pulse during the stall is ignored. out_ready = 1 -> IDLE next edge.
- Back-to-back: in_valid held high with 3 operand pairs, out_ready = 1 -> accepts spaced exactly 10 edges apart, products 0x0000 (0*0x55), 0x0019 (5*5), 0x3F01 (0x81*0x81: -127*-127 = 16129).
- Reset mid-operation: assert rst_n = 0 at the 4th ACCUM cycle of a = 0x12, b = 0x34 -> out_valid = 0, p = 0, in_ready = 1 immediately (asynchronously). A following a = 0x03, b = 0x04 yields p = 0x000C with no residue from the aborted operation.
- With PEZARIS_UNSIGNED_MODE_EN, tc_mode = 0: a = 0xFF, b = 0xFF -> p = 0xFE01 (65025). Same operands with tc_mode = 1 -> p = 0x0001.
